div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
Round-robin controller that shares one iterative 16-bit divider among NREQ requesters in the ALU. Per request it arbitrates, latches operands, launches the divider, waits for completion, and routes quotient/remainder back to the winner. It handles divide-by-zero locally without using the divider. A watchdog guards against a hung divider.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, operand/result width
TIMEOUT, 40, max WAIT cycles before abort (must exceed divider latency, 17+ cycles)

Ports:
CK  input  1  clock, all state on rising edge
RST  input  1  asynchronous active-high reset
req  input  NREQ  per-requester request level
in1_bus  input  NREQ*W  dividends; requester i at [i*W +: W]
in2_bus  input  NREQ*W  divisors; same packing
gnt  output  NREQ  one-hot, requester currently owning the divider
rsp_valid  output  NREQ  one-hot 1-cycle pulse, result for requester i
quotient  output  W  result quotient, valid with rsp_valid
reminder  output  W  result remainder, valid with rsp_valid
dbz  output  1  divide-by-zero flag, valid with rsp_valid
err_timeout  output  1  watchdog abort flag, valid with rsp_valid
busy  output  1  high in any state except IDLE
div_start  output  1  1-cycle launch pulse to divider
div_in1  output  W  latched dividend to divider
div_in2  output  W  latched divisor to divider
div_done  input  1  1-cycle completion pulse from divider
div_quo  input  W  divider quotient, valid with div_done
div_rem  input  W  divider remainder, valid with div_done

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, gnt=0, rsp_valid=0, quotient=0, reminder=0, dbz=0, err_timeout=0, busy=0, div_start=0, div_in1=0, div_in2=0, wd_cnt=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, pick first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1 .. NREQ-1, 0 ..). Latch winner index, a=in1_bus slice, b=in2_bus slice; gnt<=one-hot(winner); go ISSUE. No req: stay.
- ISSUE (1 cycle): if b==0, load quotient={W{1}}, reminder=a, dbz=1, go RESP; divider untouched. Else div_start=1, div_in1=a, div_in2=b, wd_cnt=0, go WAIT.
- WAIT: div_start=0; div_in1/div_in2 held stable. On div_done: quotient<=div_quo, reminder<=div_rem, dbz=0, go RESP. Else wd_cnt++; when wd_cnt reaches TIMEOUT-1 with no div_done: quotient=0, reminder=0, err_timeout=1, go RESP. div_done and timeout in same cycle: div_done wins.
- RESP (1 cycle): rsp_valid=one-hot(winner); quotient/reminder/dbz/err_timeout valid this cycle only (hold value until next RESP overwrites; flags clear on leaving RESP). rr_ptr<=(winner+1) mod NREQ; gnt<=0; go IDLE.
- Latency: non-zero divisor, request seen in IDLE at cycle 0 -> div_start cycle 1 -> rsp_valid 1 cycle after div_done. Zero divisor: rsp_valid at cycle 2.
- Operands sampled only in IDLE; later changes or req drop by winner ignored; result still delivered.
- Requester keeps req high until its rsp_valid; req still high after RESP counts as a new request, but rr_ptr has moved past it (fairness, no starvation: max wait NREQ transactions).
- div_done seen outside WAIT ignored.
- div_start never asserted while busy with a prior launch; exactly one div_start per non-zero-divisor transaction.

Test Plan:
- req[0], in1=100, in2=7 -> div_start 1 cycle after req, divider model returns 14/2 -> rsp_valid[0] pulse, quotient=14, reminder=2, dbz=0, gnt=0001 during op.
- req[2], in1=0x1234, in2=0 -> no div_start, rsp_valid[2] at cycle 2, quotient=0xFFFF, reminder=0x1234, dbz=1.
- req=1111 held from reset, distinct operands each -> service order 0,1,2,3,0; each rsp_valid one-hot and matches own operands.
- Winner changes in1_bus and drops req after grant (in1 100->5, in2=7) -> result still 14/2 for original operands.
- Divider model never pulses div_done -> rsp_valid after TIMEOUT WAIT cycles with err_timeout=1, quotient=0, reminder=0; next request serviced normally.
- RST asserted mid-WAIT -> all outputs 0 same cycle, state IDLE, rr_ptr=0; late div_done ignored; new req[1] completes correctly.

Source files
------------

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin controller that shares one iterative divider
// among NREQ requesters.
// Ports:
//   CK, RST                  clock, asynchronous active-high reset
//   req, in1_bus, in2_bus    per-requester request level and packed operands
//   gnt, rsp_valid           one-hot owner and one-hot result pulse
//   quotient, reminder       result data, valid with rsp_valid
//   dbz, err_timeout         divide-by-zero / watchdog flags, valid with rsp_valid
//   busy                     high whenever the controller is not idle
//   div_start, div_in1/2     launch pulse and operands to the divider
//   div_done, div_quo/rem    completion pulse and results from the divider
module div_share_ctrl #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] in1_bus,
  input  logic [NREQ*W-1:0] in2_bus,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      quotient,
  output logic [W-1:0]      reminder,
  output logic              dbz,
  output logic              err_timeout,
  output logic              busy,
  output logic              div_start,
  output logic [W-1:0]      div_in1,
  output logic [W-1:0]      div_in2,
  input  logic              div_done,
  input  logic [W-1:0]      div_quo,
  input  logic [W-1:0]      div_rem
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic [TW-1:0]      wd_cnt_q, wd_cnt_d;
  logic [NREQ-1:0]    gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       quotient_q, quotient_d, reminder_q, reminder_d;
  logic               dbz_q, dbz_d, err_timeout_q, err_timeout_d;
  logic               busy_q, busy_d, div_start_q, div_start_d;
  logic [W-1:0]       div_in1_q, div_in1_d, div_in2_q, div_in2_d;

  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic [W-1:0]       sel_a, sel_b;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] ix);
    onehot = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (ix == IW'(i)) onehot[i] = 1'b1;
    end
  endfunction

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    int cand_full;
    logic [IW-1:0] cand;
    pick_vld  = 1'b0;
    pick_idx  = '0;
    cand_full = 0;
    cand      = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand_full = int'(rr_ptr_q) + k;
      if (cand_full >= int'(NREQ)) cand_full = cand_full - int'(NREQ);
      cand = IW'(cand_full);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Operand mux for the picked requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_idx == IW'(i)) begin
        sel_a = in1_bus[i*W +: W];
        sel_b = in2_bus[i*W +: W];
      end
    end
  end

  // Next-state and registered-output logic. Outputs are computed for the
  // state being entered so they are visible during that state's cycle.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    win_d         = win_q;
    a_d           = a_q;
    b_d           = b_q;
    wd_cnt_d      = wd_cnt_q;
    gnt_d         = gnt_q;
    rsp_valid_d   = '0;
    quotient_d    = quotient_q;
    reminder_d    = reminder_q;
    dbz_d         = 1'b0;
    err_timeout_d = 1'b0;
    div_start_d   = 1'b0;
    div_in1_d     = div_in1_q;
    div_in2_d     = div_in2_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          a_d     = sel_a;
          b_d     = sel_b;
          gnt_d   = onehot(pick_idx);
          state_d = S_ISSUE;
          // Launch is pre-registered so div_start is high during ISSUE.
          if (sel_b != '0) begin
            div_start_d = 1'b1;
            div_in1_d   = sel_a;
            div_in2_d   = sel_b;
          end
        end
      end
      S_ISSUE: begin
        if (b_q == '0) begin
          quotient_d  = '1;
          reminder_d  = a_q;
          dbz_d       = 1'b1;
          rsp_valid_d = onehot(win_q);
          state_d     = S_RESP;
        end else begin
          wd_cnt_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // div_done takes priority over a simultaneous watchdog expiry.
        if (div_done) begin
          quotient_d  = div_quo;
          reminder_d  = div_rem;
          rsp_valid_d = onehot(win_q);
          state_d     = S_RESP;
        end else if (wd_cnt_q == TW'(TIMEOUT - 1)) begin
          quotient_d    = '0;
          reminder_d    = '0;
          err_timeout_d = 1'b1;
          rsp_valid_d   = onehot(win_q);
          state_d       = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + TW'(1);
        end
      end
      S_RESP: begin
        gnt_d    = '0;
        rr_ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      win_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      wd_cnt_q      <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      quotient_q    <= '0;
      reminder_q    <= '0;
      dbz_q         <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      div_start_q   <= 1'b0;
      div_in1_q     <= '0;
      div_in2_q     <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      win_q         <= win_d;
      a_q           <= a_d;
      b_q           <= b_d;
      wd_cnt_q      <= wd_cnt_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      quotient_q    <= quotient_d;
      reminder_q    <= reminder_d;
      dbz_q         <= dbz_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= busy_d;
      div_start_q   <= div_start_d;
      div_in1_q     <= div_in1_d;
      div_in2_q     <= div_in2_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign quotient    = quotient_q;
  assign reminder    = reminder_q;
  assign dbz         = dbz_q;
  assign err_timeout = err_timeout_q;
  assign busy        = busy_q;
  assign div_start   = div_start_q;
  assign div_in1     = div_in1_q;
  assign div_in2     = div_in2_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl with a fixed-latency divider model.
module tb_div_share_ctrl;

  localparam int NREQ    = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 40;
  localparam int LAT     = 17;

  logic              CK = 1'b0;
  logic              RST = 1'b1;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] in1_bus, in2_bus;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [W-1:0]      quotient, reminder;
  logic              dbz, err_timeout, busy, div_start;
  logic [W-1:0]      div_in1, div_in2;
  logic              div_done;
  logic [W-1:0]      div_quo, div_rem;

  div_share_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .CK(CK), .RST(RST), .req(req), .in1_bus(in1_bus), .in2_bus(in2_bus),
    .gnt(gnt), .rsp_valid(rsp_valid), .quotient(quotient), .reminder(reminder),
    .dbz(dbz), .err_timeout(err_timeout), .busy(busy), .div_start(div_start),
    .div_in1(div_in1), .div_in2(div_in2), .div_done(div_done),
    .div_quo(div_quo), .div_rem(div_rem)
  );

  always #5 CK = ~CK;

  typedef struct {
    int         idx;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       dbz;
    logic       tout;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   starts_seen = 0;
  int   starts_exp = 0;
  bit   hang = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse is compared against the scoreboard head.
  always @(negedge CK) begin
    if (!RST && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%0h required=none", rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_onehot", 32'(rsp_valid), 32'(1) << mon_e.idx);
        check("quotient", 32'(quotient), 32'(mon_e.q));
        check("reminder", 32'(reminder), 32'(mon_e.r));
        check("dbz", 32'(dbz), 32'(mon_e.dbz));
        check("err_timeout", 32'(err_timeout), 32'(mon_e.tout));
      end
    end
  end

  always @(negedge CK) begin
    if (!RST && div_start) starts_seen++;
  end

  // Divider model: fixed latency, ignores launches while hang is set.
  initial begin
    logic [W-1:0] ma, mb;
    div_done = 1'b0;
    div_quo  = '0;
    div_rem  = '0;
    forever begin
      @(negedge CK);
      if (!RST && div_start && !hang) begin
        ma = div_in1;
        mb = div_in2;
        repeat (LAT - 1) @(negedge CK);
        div_quo  = (mb == '0) ? '1 : ma / mb;
        div_rem  = (mb == '0) ? ma : ma % mb;
        div_done = 1'b1;
        @(negedge CK);
        div_done = 1'b0;
      end
    end
  end

  task automatic run_txn(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic edbz, input logic etout, input int exp_lat,
                         input bit tamper, input string tag);
    int n;
    bit got;
    @(negedge CK);
    in1_bus[idx*W +: W] = a;
    in2_bus[idx*W +: W] = b;
    req[idx] = 1'b1;
    sb.push_back('{idx, q, r, edbz, etout});
    if (b != '0) starts_exp++;
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge CK);
      n++;
      if (n == 1) begin
        check({tag, "_gnt_issue"}, 32'(gnt), 32'(1) << idx);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_div_start"}, 32'(div_start), 32'(b != '0));
        if (b != '0) begin
          check({tag, "_div_in1"}, 32'(div_in1), 32'(a));
          check({tag, "_div_in2"}, 32'(div_in2), 32'(b));
        end
        if (tamper) begin
          in1_bus[idx*W +: W] = 16'd5;
          req[idx] = 1'b0;
        end
      end
      if (n == 2) begin
        check({tag, "_gnt_hold"}, 32'(gnt), 32'(1) << idx);
        if (b != '0) check({tag, "_start_pulse"}, 32'(div_start), 32'd0);
      end
      if (rsp_valid[idx]) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    req[idx] = 1'b0;
    @(negedge CK);
    check({tag, "_post_rsp"}, 32'(rsp_valid), 32'd0);
    check({tag, "_post_flags"}, {30'd0, dbz, err_timeout}, 32'd0);
    check({tag, "_post_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_quo_hold"}, 32'(quotient), 32'(q));
  endtask

  task automatic wait_resp(input int nexp, input bit drop_each, input string tag);
    int got, cyc;
    got = 0;
    cyc = 0;
    while (got < nexp && cyc < 500) begin
      @(negedge CK);
      cyc++;
      if (rsp_valid != '0) begin
        got++;
        if (drop_each) req = req & ~rsp_valid;
      end
    end
    check({tag, "_resp_count"}, 32'(got), 32'(nexp));
  endtask

  initial begin
    int busy_cnt;
    req     = '0;
    in1_bus = '0;
    in2_bus = '0;

    // Round-robin operands, request held across reset release.
    in1_bus[0*W +: W] = 16'd100;   in2_bus[0*W +: W] = 16'd7;
    in1_bus[1*W +: W] = 16'd1000;  in2_bus[1*W +: W] = 16'd10;
    in1_bus[2*W +: W] = 16'hFFFF;  in2_bus[2*W +: W] = 16'd256;
    in1_bus[3*W +: W] = 16'd50;    in2_bus[3*W +: W] = 16'd0;
    req = 4'b1111;

    repeat (2) @(negedge CK);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_reminder", 32'(reminder), 32'd0);
    check("rst_flags", {30'd0, dbz, err_timeout}, 32'd0);
    check("rst_div_in", {div_in1, div_in2}, 32'd0);

    sb.push_back('{0, 16'd14, 16'd2, 1'b0, 1'b0});
    sb.push_back('{1, 16'd100, 16'd0, 1'b0, 1'b0});
    sb.push_back('{2, 16'd255, 16'd255, 1'b0, 1'b0});
    sb.push_back('{3, 16'hFFFF, 16'd50, 1'b1, 1'b0});
    sb.push_back('{0, 16'd14, 16'd2, 1'b0, 1'b0});
    starts_exp += 4;
    RST = 1'b0;
    wait_resp(5, 1'b0, "rr");
    req = '0;

    run_txn(0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, LAT + 1, 1'b0, "basic");
    run_txn(2, 16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 2, 1'b0, "dbz");
    run_txn(0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, LAT + 1, 1'b1, "tamper");
    hang = 1'b1;
    run_txn(3, 16'd9, 16'd3, 16'd0, 16'd0, 1'b0, 1'b1, TIMEOUT + 2, 1'b0, "tout");
    hang = 1'b0;
    run_txn(1, 16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 1'b0, LAT + 1, 1'b0, "after_tout");

    // Reset in the middle of WAIT; the divider's late completion must be ignored.
    @(negedge CK);
    in1_bus[2*W +: W] = 16'd500;
    in2_bus[2*W +: W] = 16'd9;
    req[2] = 1'b1;
    starts_exp++;
    repeat (5) @(negedge CK);
    check("pre_rst_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    check("mid_rst_div", {15'd0, div_start, div_in1}, 32'd0);
    check("mid_rst_result", {quotient, reminder}, 32'd0);
    req = '0;
    @(negedge CK);
    RST = 1'b0;
    busy_cnt = 0;
    repeat (20) begin
      @(negedge CK);
      if (busy || rsp_valid != '0) busy_cnt++;
    end
    check("late_done_ignored", 32'(busy_cnt), 32'd0);

    // rr_ptr back at 0: requester 1 must win over requester 3.
    @(negedge CK);
    in1_bus[1*W +: W] = 16'd20;  in2_bus[1*W +: W] = 16'd6;
    in1_bus[3*W +: W] = 16'd77;  in2_bus[3*W +: W] = 16'd0;
    sb.push_back('{1, 16'd3, 16'd2, 1'b0, 1'b0});
    sb.push_back('{3, 16'hFFFF, 16'd77, 1'b1, 1'b0});
    starts_exp++;
    req = 4'b1010;
    wait_resp(2, 1'b1, "post_rst");
    req = '0;

    repeat (3) @(negedge CK);
    check("div_start_count", 32'(starts_seen), 32'(starts_exp));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
